// File: rtl/chany_track_pipe.sv
// Per-track bypass / retiming stage for vertical routing channels, configured by a serial chain.
// Optional macro CHANY_PIPE_TWO_STAGE_EN adds the second retiming flop used by mode 10.
module chany_track_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] chany_top_in,
    input  logic [0:WIDTH-1] chany_bottom_in,
    output logic [0:WIDTH-1] chany_top_out,
    output logic [0:WIDTH-1] chany_bottom_out,
    input  logic             ccff_head,
    input  logic             ccff_en,
    output logic             ccff_tail,
    output logic             cfg_valid
);

    localparam int CHAIN  = 4 * WIDTH;
    localparam int CW     = $clog2(CHAIN);
    localparam int TRACKS = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(CHAIN - 1);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_ONE    = 2'b01,
        MODE_TWO    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [0:CHAIN-1]  sr;
    logic [0:CHAIN-1]  sr_next;
    logic [0:CHAIN-1]  shadow;
    logic [CW-1:0]     cnt;
    logic [0:TRACKS-1] din;
    logic [0:TRACKS-1] q1;
    logic [0:TRACKS-1] dout;
    mode_e             mode [TRACKS];

    // Top tracks occupy slots 0..WIDTH-1, bottom tracks WIDTH..2*WIDTH-1, so
    // slot t always reads its mode from shadow[2t] (MSB) and shadow[2t+1].
    assign din              = {chany_top_in, chany_bottom_in};
    assign chany_top_out    = dout[0:WIDTH-1];
    assign chany_bottom_out = dout[WIDTH:TRACKS-1];
    assign ccff_tail        = sr[CHAIN-1];
    assign sr_next          = {ccff_head, sr[0:CHAIN-2]};

    // NOTE: every flop here is reset, including the wide chain and shadow, so
    // that reset reliably returns all tracks to bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            shadow    <= '0;
            cnt       <= '0;
            cfg_valid <= 1'b0;
        end else if (ccff_en) begin
            // NOTE: non-blocking assignments so shadow captures sr_next, the
            // chain value including the bit entering on this edge.
            sr <= sr_next;
            if (cnt == LAST) begin
                cnt       <= '0;
                shadow    <= sr_next;
                cfg_valid <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        for (int t = 0; t < TRACKS; t++) begin
            mode[t] = mode_e'({shadow[2*t], shadow[2*t+1]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
        end else begin
            for (int t = 0; t < TRACKS; t++) begin
                if (mode[t] != MODE_HOLD) q1[t] <= din[t];
            end
        end
    end

`ifdef CHANY_PIPE_TWO_STAGE_EN
    logic [0:TRACKS-1] q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q2 <= '0;
        else        q2 <= q1;
    end
`endif

    // NOTE: dout gets a default before the case so no latch is inferred.
    always_comb begin
        dout = din;
        for (int t = 0; t < TRACKS; t++) begin
            case (mode[t])
                MODE_BYPASS: dout[t] = din[t];
                MODE_ONE:    dout[t] = q1[t];
`ifdef CHANY_PIPE_TWO_STAGE_EN
                MODE_TWO:    dout[t] = q2[t];
`else
                MODE_TWO:    dout[t] = q1[t];
`endif
                MODE_HOLD:   dout[t] = q1[t];
                default:     dout[t] = din[t];
            endcase
        end
    end

endmodule

// File: tb/tb_chany_track_pipe.sv
// Directed self-checking bench for chany_track_pipe (WIDTH=32); expectations follow the
// CHANY_PIPE_TWO_STAGE_EN setting of the build.
module tb_chany_track_pipe;

    localparam int WIDTH = 32;
    localparam int CHAIN = 4 * WIDTH;
`ifdef CHANY_PIPE_TWO_STAGE_EN
    localparam bit TWO = 1'b1;
`else
    localparam bit TWO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [0:WIDTH-1] chany_top_in;
    logic [0:WIDTH-1] chany_bottom_in;
    logic [0:WIDTH-1] chany_top_out;
    logic [0:WIDTH-1] chany_bottom_out;
    logic             ccff_head;
    logic             ccff_en;
    logic             ccff_tail;
    logic             cfg_valid;

    int checks   = 0;
    int failures = 0;

    chany_track_pipe #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .chany_top_in     (chany_top_in),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_out    (chany_top_out),
        .chany_bottom_out (chany_bottom_out),
        .ccff_head        (ccff_head),
        .ccff_en          (ccff_en),
        .ccff_tail        (ccff_tail),
        .cfg_valid        (cfg_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Chain bit i ends at sr[i] after a full load, so bit 127 is shifted first.
    task automatic shift_bits(input logic [0:CHAIN-1] bits, input int first, input int count);
        for (int j = first; j < first + count; j++) begin
            ccff_head = bits[CHAIN-1-j];
            ccff_en   = 1'b1;
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    function automatic logic [0:CHAIN-1] all_modes(input logic [1:0] m);
        logic [0:CHAIN-1] r;
        for (int t = 0; t < 2 * WIDTH; t++) begin
            r[2*t]   = m[1];
            r[2*t+1] = m[0];
        end
        return r;
    endfunction

    logic [0:CHAIN-1] cfg;

    initial begin
        rst_n           = 1'b0;
        ccff_head       = 1'b0;
        ccff_en         = 1'b0;
        chany_top_in    = 32'h0;
        chany_bottom_in = 32'h0;
        #1;
        check("reset_tail", ccff_tail, 1'b0);
        check("reset_valid", cfg_valid, 1'b0);
        chany_top_in    = 32'hA5A5_5A5A;
        chany_bottom_in = 32'h0F0F_3C3C;
        #1;
        check("reset_bypass_top", chany_top_out, 32'hA5A5_5A5A);
        check("reset_bypass_bot", chany_bottom_out, 32'h0F0F_3C3C);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_valid", cfg_valid, 1'b0);
        check("idle_bypass_top", chany_top_out, 32'hA5A5_5A5A);

        // Mode 01 everywhere, loaded with a 10-cycle enable gap before the last bit.
        chany_bottom_in = 32'hCAFE_F00D;
        cfg = all_modes(2'b01);
        shift_bits(cfg, 0, CHAIN - 1);
        check("gap_start_valid", cfg_valid, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chany_top_in = 32'h5A5A_A5A5;
        #1;
        check("gap_end_valid", cfg_valid, 1'b0);
        check("gap_modes_bypass", chany_top_out, 32'h5A5A_A5A5);
        shift_bits(cfg, CHAIN - 1, 1);
        check("load01_valid", cfg_valid, 1'b1);
        check("load01_q1_bot", chany_bottom_out, 32'hCAFE_F00D);
        chany_bottom_in = 32'h1234_5678;
        #1;
        check("load01_not_bypass", chany_bottom_out, 32'hCAFE_F00D);
        tick();
        check("load01_latency1", chany_bottom_out, 32'h1234_5678);

        // Mode 10: single-cycle pulse on top track 0.
        chany_top_in = 32'h0;
        shift_bits(all_modes(2'b10), 0, CHAIN);
        check("load10_valid_stays", cfg_valid, 1'b1);
        tick();
        check("mode10_idle", chany_top_out, 32'h0);
        chany_top_in = 32'h8000_0000;
        tick();
        chany_top_in = 32'h0;
        #1;
        check("mode10_cycle1", chany_top_out, TWO ? 32'h0 : 32'h8000_0000);
        tick();
        check("mode10_cycle2", chany_top_out, TWO ? 32'h8000_0000 : 32'h0);
        tick();
        check("mode10_cycle3", chany_top_out, 32'h0);

        // Mode 11 on bottom track 5, 01 elsewhere; track 5 captured 1 at commit.
        cfg = all_modes(2'b01);
        cfg[2*(WIDTH+5)]   = 1'b1;
        cfg[2*(WIDTH+5)+1] = 1'b1;
        chany_bottom_in = 32'hFFFF_FFFF;
        shift_bits(cfg, 0, CHAIN);
        chany_bottom_in = 32'h0;
        tick();
        check("hold_toggle0", chany_bottom_out, 32'h0400_0000);
        chany_bottom_in = 32'hFFFF_FFFF;
        tick();
        check("hold_toggle1", chany_bottom_out, 32'hFFFF_FFFF);
        chany_bottom_in = 32'h0;
        tick();
        check("hold_toggle2", chany_bottom_out, 32'h0400_0000);

        // Partial load, then asynchronous reset mid-load and mid-stream.
        shift_bits(all_modes(2'b11), 0, 50);
        chany_top_in = 32'h1357_9BDF;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_bypass_top", chany_top_out, 32'h1357_9BDF);
        check("rst_bypass_bot", chany_bottom_out, 32'h0);
        check("rst_valid", cfg_valid, 1'b0);
        check("rst_cnt", dut.cnt, 0);
        check("rst_tail", ccff_tail, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single 1 then zeros: reaches the tail after exactly 128 enabled edges.
        cfg = '0;
        cfg[CHAIN-1] = 1'b1;
        shift_bits(cfg, 0, CHAIN - 1);
        check("tail_127", ccff_tail, 1'b0);
        check("valid_127_after_rst", cfg_valid, 1'b0);
        shift_bits(cfg, CHAIN - 1, 1);
        check("tail_128", ccff_tail, 1'b1);
        check("valid_128_after_rst", cfg_valid, 1'b1);
        // Only bottom track 31 is mode 01: its output is the pre-commit input (0).
        chany_bottom_in = 32'hFFFF_FFFF;
        #1;
        check("single_track_mode", chany_bottom_out, 32'hFFFF_FFFE);

        // A second full load of zeros keeps cfg_valid high and restores bypass.
        shift_bits(all_modes(2'b00), 0, 1);
        check("tail_129", ccff_tail, 1'b0);
        shift_bits(all_modes(2'b00), 1, CHAIN - 1);
        check("reload_valid", cfg_valid, 1'b1);
        chany_bottom_in = 32'h2468_ACE0;
        #1;
        check("reload_bypass", chany_bottom_out, 32'h2468_ACE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chany_track_pipe.md
# chany_track_pipe

Configurable per-track pipeline stage for vertical routing channels. It sits directly downstream of a Y connection block, where it consumes that block's `chany_top_out` and `chany_bottom_out` buses. Each track can be passed through combinationally or retimed by one or two flops. Track modes are loaded through a configuration-chain shift register on the fabric clock. A completed load commits the modes atomically into a shadow register.

## Interface
- `WIDTH`, default 32: number of tracks per direction.
- `clk`  input  1  fabric clock; clocks data flops, config chain and counter.
- `rst_n`  input  1  asynchronous, active-low reset.
- `chany_top_in`  input  [0:WIDTH-1]  tracks travelling upward, from the connection block's `chany_top_out`.
- `chany_bottom_in`  input  [0:WIDTH-1]  tracks travelling downward, from the connection block's `chany_bottom_out`.
- `chany_top_out`  output  [0:WIDTH-1]  upward tracks after bypass or retiming.
- `chany_bottom_out`  output  [0:WIDTH-1]  downward tracks after bypass or retiming.
- `ccff_head`  input  1  serial configuration data in.
- `ccff_en`  input  1  shift enable for the configuration chain.
- `ccff_tail`  output  1  serial configuration data out, last chain bit.
- `cfg_valid`  output  1  high once at least one complete load has been committed.

## Operation
- **Shift register**
  - `sr[0:4*WIDTH-1]`.
  - On `ccff_en`=1: `sr[0]<=ccff_head`, `sr[i]<=sr[i-1]`.
  - `ccff_tail = sr[4*WIDTH-1]`.
- **Bit counter**
  - `cnt`, width `$clog2(4*WIDTH)`, increments on each enabled shift.
  - On the shift where `cnt==4*WIDTH-1`:
    - `cnt<=0`.
    - `shadow<=` post-shift `sr` value, including the bit entering this edge.
    - `cfg_valid<=1`.
- **Mode mapping** (from `shadow`)
  - Top track k: `{shadow[2k], shadow[2k+1]}`.
  - Bottom track k: `{shadow[2*WIDTH+2k], shadow[2*WIDTH+2k+1]}`.
  - The first bit is the MSB in both cases.
- **Mode encoding**
  - 00: bypass; `out=in` combinationally.
  - 01: one stage; `out=q1`, `q1<=in`.
  - 10: two stages; `out=q2`, `q2<=q1`. See Configuration.
  - 11: hold; `out=q1`, and `q1` is frozen (no update).
- `q1`/`q2` update every cycle regardless of mode, except `q1` in mode 11. A mode change therefore outputs already-primed data immediately.
- **Boundary conditions**
  - `ccff_en` dropped mid-load: `cnt` and `sr` hold; the load resumes when `ccff_en` returns. `shadow` is unchanged until the count completes.
  - A load completes while data is flowing: the new modes take effect on the cycle after the committing edge, with no glitch state.
  - Consecutive full loads: each completion commits again, and `cfg_valid` stays 1.
  - `rst_n` low at any time, including mid-load or mid-stream, asynchronously clears the following:
    - `sr`, `cnt`, `shadow`, `q1`, `q2`, `cfg_valid`.
    - All tracks return to bypass.

## Timing
- **Reset values**
  - `ccff_tail`=0, `cfg_valid`=0.
  - `chany_*_out` equal `chany_*_in` (bypass, combinational), since `shadow`=0.
- **Latency**
  - Mode 00: 0 cycles.
  - Mode 01: 1 cycle.
  - Mode 10: 2 cycles (macro defined).
  - Mode 11: holds the last captured value indefinitely.
- **Config path**
  - A bit presented on `ccff_head` appears on `ccff_tail` after 4*WIDTH enabled edges.
  - `cfg_valid` and the new modes are visible in the cycle after the 4*WIDTH-th enabled edge.
- No handshakes on the data path; tracks are free-running.

## Configuration
- Macro: `CHANY_PIPE_TWO_STAGE_EN`.
- **Defined:**
  - The `q2` flops are instantiated.
  - Mode 10 gives 2-cycle latency.
- **Undefined:**
  - No `q2` flops are instantiated.
  - Mode 10 behaves exactly as mode 01 (`out=q1`, 1-cycle latency).
  - The chain length and encoding are unchanged, so the same bitstream loads in both builds.

## Test plan
- Reset, no load, WIDTH=32 -> `cfg_valid`=0; `chany_top_in`=32'hA5A5_5A5A appears on `chany_top_out` in the same cycle.
- Shift 128 bits of pattern "01" repeated -> `cfg_valid` rises the cycle after the 128th edge. Then `chany_bottom_in`=32'h1234_5678 appears on `chany_bottom_out` exactly 1 cycle later.
- Load mode 10 on all tracks, macro defined -> a single-cycle pulse on top track 0 is seen 2 cycles later. With the macro undefined -> the same pulse is seen 1 cycle later.
- Shift 127 bits, drop `ccff_en` for 10 cycles, then shift 1 more bit -> `shadow` and `cfg_valid` change only after the final bit. Modes are unchanged during the gap.
- Load mode 11 on bottom track 5 while its input toggles -> the output stays at the value captured before the commit. Then assert `rst_n`=0 mid-stream -> all outputs revert to bypass immediately, `cfg_valid`=0, `cnt`=0.
- Shift a single 1 followed by zeros -> `ccff_tail` goes high exactly 128 enabled edges after the 1 entered.
